// File: rtl/kf_pkg.sv
// Shared Kalman core definitions: FSM state encoding, word-format defaults and
// two's-complement <-> sign-magnitude conversion helpers.
package kf_pkg;

    localparam int KF_W    = 24;
    localparam int KF_FRAC = 14;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_START,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_WAIT_IDLE
    } kf_state_t;

    // The most negative input has no sign-magnitude image; it saturates to -max.
    function automatic logic [KF_W-1:0] tc_to_sm(input logic [KF_W-1:0] x);
        logic [KF_W-1:0] neg;
        neg = -x;
        if (!x[KF_W-1])
            return x;
        if (x[KF_W-2:0] == '0)
            return '1;
        return {1'b1, neg[KF_W-2:0]};
    endfunction

    function automatic logic [KF_W-1:0] sm_to_tc(input logic [KF_W-1:0] s);
        logic [KF_W-1:0] mag;
        mag = {1'b0, s[KF_W-2:0]};
        return s[KF_W-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/kf_sm_conv.sv
// Combinational converter pair: two's complement -> sign-magnitude (host to core)
// and sign-magnitude -> two's complement (core to host); zero latency, no flow control.
module kf_sm_conv
    import kf_pkg::*;
#(
    parameter int W = KF_W
) (
    input  logic [W-1:0] tc_in,
    output logic [W-1:0] sm_out,
    input  logic [W-1:0] sm_in,
    output logic [W-1:0] tc_out
);

    logic [W-1:0] tc_neg;
    logic [W-1:0] mag;

    assign tc_neg = -tc_in;

    always_comb begin
        sm_out = tc_in;
        if (tc_in[W-1]) begin
            if (tc_in[W-2:0] == '0)
                sm_out = '1;
            else
                sm_out = {1'b1, tc_neg[W-2:0]};
        end
    end

    // Negative zero negates to zero, so it needs no special case.
    assign mag    = {1'b0, sm_in[W-2:0]};
    assign tc_out = sm_in[W-1] ? -mag : mag;

endmodule

// File: rtl/kf_host_if.sv
// Host driver for the Kalman core: collects N_IN operands, starts and loads the core,
// captures up to N_OUT results; start 2 cycles after last operand; results held under out_ready stall.
module kf_host_if
    import kf_pkg::*;
#(
    parameter int W       = KF_W,
    parameter int N_IN    = 2,
    parameter int N_OUT   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         kf_start,
    output logic [W-1:0] kf_data,
    input  logic         kf_ready,
    input  logic [W-1:0] kf_result,
    input  logic         kf_au_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int RW = $clog2(N_OUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    kf_state_t     state;
    logic [IW-1:0] wr_cnt;
    logic [IW-1:0] k;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rd;
    logic [TW-1:0] tcnt;
    logic [W-1:0]  ibuf [N_IN];
    logic [W-1:0]  obuf [N_OUT];
    logic          kf_ready_q;
    logic [W-1:0]  in_sm;

    kf_sm_conv #(.W(W)) u_conv (
        .tc_in  (in_data),
        .sm_out (in_sm),
        .sm_in  (obuf[rd]),
        .tc_out (out_data)
    );

    assign in_ready  = (state == ST_COLLECT);
    assign busy      = (state != ST_COLLECT);
    assign kf_start  = (state == ST_START);
    assign out_valid = (state == ST_DRAIN) && (rcnt != '0);
    assign out_last  = out_valid && (rd == rcnt - RW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_COLLECT;
            wr_cnt     <= '0;
            k          <= '0;
            rcnt       <= '0;
            rd         <= '0;
            tcnt       <= '0;
            ibuf       <= '{default: '0};
            obuf       <= '{default: '0};
            kf_data    <= '0;
            err        <= 1'b0;
            kf_ready_q <= 1'b0;
        end else begin
            kf_ready_q <= kf_ready;
            case (state)
                ST_COLLECT: begin
                    if (in_valid) begin
                        ibuf[wr_cnt] <= in_sm;
                        // kf_data rests on word 0 so START and LOAD0 need no update.
                        if (wr_cnt == '0)
                            kf_data <= in_sm;
                        if (wr_cnt == IW'(N_IN - 1)) begin
                            wr_cnt <= '0;
                            state  <= ST_WAIT_IDLE;
                        end else begin
                            wr_cnt <= wr_cnt + IW'(1);
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (kf_ready)
                        state <= ST_START;
                end
                ST_START: begin
                    err   <= 1'b0;
                    rcnt  <= '0;
                    rd    <= '0;
                    k     <= '0;
                    tcnt  <= '0;
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (k == IW'(N_IN - 1)) begin
                        kf_data <= ibuf[0];
                        state   <= ST_RUN;
                    end else begin
                        kf_data <= ibuf[k + IW'(1)];
                        k       <= k + IW'(1);
                    end
                end
                ST_RUN: begin
                    tcnt <= tcnt + TW'(1);
                    if (kf_au_done) begin
                        if (rcnt == RW'(N_OUT)) begin
                            err <= 1'b1;
                        end else begin
                            obuf[rcnt] <= kf_result;
                            rcnt       <= rcnt + RW'(1);
                        end
                    end
                    // Completion is the core returning to idle, not merely being idle.
                    if (kf_ready && !kf_ready_q) begin
                        state <= ST_DRAIN;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rcnt == '0) begin
                        state <= ST_COLLECT;
                    end else if (out_ready) begin
                        if (rd == rcnt - RW'(1)) begin
                            rd    <= '0;
                            state <= ST_COLLECT;
                        end else begin
                            rd <= rd + RW'(1);
                        end
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_kf_host_if.sv
// Directed bench for kf_host_if: a small core model drives results, a scoreboard checks the host stream.
module tb_kf_host_if;

    localparam int W       = 24;
    localparam int N_IN    = 2;
    localparam int N_OUT   = 3;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         kf_ready = 1'b1;
    logic [W-1:0] kf_result = '0;
    logic         kf_au_done = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, kf_start, out_valid, out_last, busy, err;
    logic [W-1:0] kf_data, out_data;

    kf_host_if #(.W(W), .N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .kf_start   (kf_start),
        .kf_data    (kf_data),
        .kf_ready   (kf_ready),
        .kf_result  (kf_result),
        .kf_au_done (kf_au_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference conversions from the numeric meaning of each format.
    function automatic logic [W-1:0] m_sm(input logic [W-1:0] x);
        int v, mag;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag > 32'h7FFFFF) mag = 32'h7FFFFF;
        return {(v < 0), mag[22:0]};
    endfunction

    function automatic logic [W-1:0] m_tc(input logic [W-1:0] s);
        int v, mag;
        mag = int'({1'b0, s[22:0]});
        v   = s[23] ? -mag : mag;
        return v[23:0];
    endfunction

    logic [W-1:0] exp_q[$];
    bit           last_q[$];
    logic [W-1:0] res_tab[4];
    logic [W-1:0] lit_tab[4];
    bit           exp_err;
    bit           rand_bp = 1'b0;
    int           run_start_cyc = 0;
    int           err_rise_cyc = 0;
    int           start_cnt = 0;

    // Downstream backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard, stall stability, state-derived handshakes.
    initial begin
        bit           stall = 1'b0;
        bit           err_d = 1'b0;
        logic [W-1:0] hold_data = '0;
        bit           hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                err_d = 1'b0;
            end else begin
                check("in_ready_vs_busy", in_ready, !busy);
                if (kf_start) start_cnt++;
                if (err && !err_d) err_rise_cyc = cyc;
                err_d = err;
                if (stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, hold_data);
                    check("stall_last", out_last, hold_last);
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got 0x%0h, expected none", out_data);
                    end else begin
                        logic [W-1:0] e;
                        bit           l;
                        e = exp_q.pop_front();
                        l = last_q.pop_front();
                        check("out_data", out_data, e);
                        check("out_last", out_last, l);
                    end
                end
                stall     = out_valid && !out_ready;
                hold_data = out_data;
                hold_last = out_last;
            end
        end
    end

    task automatic send_word(input logic [W-1:0] x);
        int t = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = x;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("send_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic set_tab(input logic [W-1:0] r0, r1, r2, r3, l0, l1, l2, l3);
        res_tab = '{r0, r1, r2, r3};
        lit_tab = '{l0, l1, l2, l3};
    endtask

    // Core model: acknowledges start, records bank writes, emits n results.
    task automatic core_run(input logic [W-1:0] w0, w1, lit0, lit1,
                            input int n, input bit finish, output int t_start);
        int t = 0;
        int nkeep;
        do begin
            @(negedge clk);
            t++;
        end while (!kf_start && t < 50);
        t_start = t;
        check("kf_start_seen", kf_start, 1);
        if (!kf_start) return;
        check("model_sm0", m_sm(w0), lit0);
        check("model_sm1", m_sm(w1), lit1);
        check("start_data", kf_data, m_sm(w0));
        @(posedge clk); #1;
        kf_ready = 1'b0;
        @(negedge clk);
        check("db0_data", kf_data, m_sm(w0));
        check("start_one_cycle", kf_start, 0);
        @(negedge clk);
        check("db1_data", kf_data, m_sm(w1));
        @(posedge clk); #1;
        run_start_cyc = cyc;
        nkeep   = (n > N_OUT) ? N_OUT : n;
        exp_err = !finish || (n > N_OUT);
        for (int i = 0; i < nkeep; i++) begin
            check("model_tc", m_tc(res_tab[i]), lit_tab[i]);
            exp_q.push_back(m_tc(res_tab[i]));
            last_q.push_back(i == nkeep - 1);
        end
        for (int i = 0; i < n; i++) begin
            kf_au_done = 1'b1;
            kf_result  = res_tab[i];
            if (finish && i == n - 1) kf_ready = 1'b1;
            @(posedge clk); #1;
            kf_au_done = 1'b0;
            @(posedge clk); #1;
        end
        if (finish && n == 0) kf_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 3000);
        check("run_complete", busy, 0);
        check("err_flag", err, exp_err);
        check("all_drained", exp_q.size(), 0);
        if (!finish) begin
            check("timeout_cycles", (err_rise_cyc - run_start_cyc == TIMEOUT) ||
                                    (err_rise_cyc - run_start_cyc == TIMEOUT + 1), 1);
            @(posedge clk); #1;
            kf_ready = 1'b1;
        end
        exp_q.delete();
        last_q.delete();
    endtask

    initial begin
        int ts;
        int sc;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_kf_start", kf_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        check("rst_kf_data", kf_data, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Nominal run.
        set_tab(24'h016000, 24'h002000, 24'h01E000, 24'h0, 24'h016000, 24'h002000, 24'h01E000, 24'h0);
        send_word(24'h00C000);
        send_word(24'h00A000);
        core_run(24'h00C000, 24'h00A000, 24'h00C000, 24'h00A000, 3, 1'b1, ts);
        check("min_start_latency", ts, 2);

        // Conversion edges.
        set_tab(24'h800000, 24'h812345, 24'h0, 24'h0, 24'h000000, 24'hFEDCBB, 24'h0, 24'h0);
        send_word(24'hFFC000);
        send_word(24'h800000);
        core_run(24'hFFC000, 24'h800000, 24'h804000, 24'hFFFFFF, 2, 1'b1, ts);

        // Core busy before start.
        kf_ready = 1'b0;
        set_tab(24'h800001, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0);
        send_word(24'h000001);
        send_word(24'hFFFFFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("start_held_low", kf_start, 0);
        end
        @(posedge clk); #1;
        kf_ready = 1'b1;
        sc = start_cnt;
        core_run(24'h000001, 24'hFFFFFF, 24'h000001, 24'h800001, 1, 1'b1, ts);
        check("start_after_ready", ts, 2);
        check("start_pulse_count", start_cnt - sc, 1);

        // Timeout.
        set_tab(24'h000100, 24'h800100, 24'h0, 24'h0, 24'h000100, 24'hFFFF00, 24'h0, 24'h0);
        send_word(24'h00C000);
        send_word(24'h00A000);
        core_run(24'h00C000, 24'h00A000, 24'h00C000, 24'h00A000, 2, 1'b0, ts);

        // Overflow with random backpressure.
        rand_bp = 1'b1;
        set_tab(24'h000010, 24'h800020, 24'h000030, 24'h000040,
                24'h000010, 24'hFFFFE0, 24'h000030, 24'h000040);
        send_word(24'h001000);
        send_word(24'hFFF000);
        core_run(24'h001000, 24'hFFF000, 24'h001000, 24'h801000, 4, 1'b1, ts);
        rand_bp = 1'b0;

        // No results: drain is skipped.
        send_word(24'h7FFFFF);
        send_word(24'h000000);
        core_run(24'h7FFFFF, 24'h000000, 24'h7FFFFF, 24'h000000, 0, 1'b1, ts);

        // Reset in LOAD cycle 1.
        send_word(24'h00C000);
        send_word(24'h00A000);
        ts = 0;
        do begin
            @(negedge clk);
            ts++;
        end while (!kf_start && ts < 50);
        check("reset_run_start", kf_start, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_kf_data", kf_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_kf_start", kf_start, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_tab(24'h016000, 24'h002000, 24'h01E000, 24'h0, 24'h016000, 24'h002000, 24'h01E000, 24'h0);
        send_word(24'h00C000);
        send_word(24'h00A000);
        core_run(24'h00C000, 24'h00A000, 24'h00C000, 24'h00A000, 3, 1'b1, ts);
        check("post_rst_latency", ts, 2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
